// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, terminator word, word geometry.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Big-endian byte-to-word assembler; flags the byte that completes a 32-bit word.
module instr_loader_byte_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [23:0]           shift_q;
  logic                  take;

  assign take = accept && rx_valid;

  // word_valid marks the 4th byte in its own cycle; the owner registers the write.
  assign word_valid = take && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word       = {shift_q, rx_data};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (take) begin
      byte_cnt <= byte_cnt + 1'b1;
      shift_q  <= {shift_q[15:0], rx_data};
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads big-endian program words from a UART byte stream into instruction memory.
// Optional INSTR_LOADER_CHECKSUM_EN adds o_checksum, the XOR of all words written this load.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,output logic [31:0]      o_checksum
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              start_ok;
  logic              word_valid;
  logic [31:0]       word;
  logic              is_halt;
  logic              at_top;

  assign start_ok = i_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign is_halt  = (word == HALT_WORD);
  assign at_top   = (addr_q == '1);

  instr_loader_byte_assembler u_asm (
    .clk        (clk),
    .reset      (i_reset),
    .clear      (start_ok),
    .accept     (state_q == ST_LOAD),
    .rx_data    (i_rx_data),
    .rx_valid   (i_rx_valid),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Leaving LOAD coincides with the write, so a byte in the write cycle is dropped on the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_LOAD;
      ST_LOAD: if (word_valid && (is_halt || at_top)) state_d = ST_DONE;
      ST_DONE: if (i_start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == ST_LOAD);
    o_done = (state_q == ST_DONE);
  end

  // o_mem_wr_en is a one-cycle strobe; address and data are valid with it and hold afterwards.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      addr_q       <= '0;
      o_mem_wr_en  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
    end else begin
      o_mem_wr_en <= word_valid;
      if (start_ok) begin
        addr_q       <= '0;
        o_word_count <= '0;
        o_overflow   <= 1'b0;
      end else if (word_valid) begin
        o_mem_addr   <= addr_q;
        o_mem_data   <= word;
        o_word_count <= o_word_count + 1'b1;
        if (!is_halt) begin
          if (at_top) o_overflow <= 1'b1;
          else        addr_q     <= addr_q + 1'b1;
        end
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (i_reset || start_ok) o_checksum <= '0;
    else if (word_valid)     o_checksum <= o_checksum ^ word;
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed scoreboard bench for instr_loader, built with ADDR_W=2 so memory-full is reachable.
module tb_instr_loader;

  localparam int AW = 2;
  localparam int W  = 32 + (AW + 1) + AW + 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          busy, done, overflow;
  logic [AW:0]   word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] cyc = '0;
  logic [31:0] last_cyc = '0;
  logic [W-1:0] exp_q[$];

  instr_loader #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_mem_wr_en  (mem_wr_en),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_word_count (word_count)
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,.o_checksum  (checksum)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic expect_wr,
                           input logic [AW-1:0] addr, input logic [AW:0] cnt);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    if (expect_wr) exp_q.push_back({last_cyc + 32'd1, cnt, addr, w});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got addr %0h data %h at cycle %0d, expected no write",
                 mem_addr, mem_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_cycle", cyc, e[W-1 -: 32]);
        check("wr_count", word_count, e[AW+1+AW+31 -: AW+1]);
        check("wr_addr", mem_addr, e[AW+31 -: AW]);
        check("wr_data", mem_data, e[31:0]);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", word_count, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif

    // bytes in IDLE are ignored
    send_word(32'hAAAA_AAAA, 0, 1'b0, 0, 0);
    idle(2);

    // basic load
    pulse_start();
    check("start_busy", busy, 1);
    send_word(32'h2008_0005, 1, 1'b1, 0, 1);
    send_word(32'hFFFF_FFFF, 2, 1'b1, 1, 2);
    idle(2);
    check("basic_done", done, 1);
    check("basic_busy", busy, 0);
    check("basic_count", word_count, 2);
    check("basic_overflow", overflow, 0);
    check("hold_addr", mem_addr, 1);
    check("hold_data", mem_data, 32'hFFFF_FFFF);

    // bytes in DONE ignored; reload clears counters
    send_word(32'h1122_3344, 0, 1'b0, 0, 0);
    idle(1);
    pulse_start();
    check("reload_count", word_count, 0);
    check("reload_busy", busy, 1);
    check("reload_done", done, 0);

    // back-to-back bytes
    send_word(32'h0102_0304, 0, 1'b1, 0, 1);
    send_word(32'h0506_0708, 0, 1'b1, 1, 2);
    send_word(32'hFFFF_FFFF, 0, 1'b1, 2, 3);
    idle(2);
    check("b2b_done", done, 1);
    check("b2b_count", word_count, 3);

    // start mid-load is ignored, address continues
    pulse_start();
    send_word(32'hA0B0_C0D0, 0, 1'b1, 0, 1);
    pulse_start();
    send_word(32'h1122_3344, 0, 1'b1, 1, 2);
    send_word(32'hFFFF_FFFF, 1, 1'b1, 2, 3);
    idle(2);
    check("midstart_done", done, 1);
    check("midstart_count", word_count, 3);

    // memory full without HALT; trailing bytes produce no strobe
    pulse_start();
    send_word(32'h0000_0001, 0, 1'b1, 0, 1);
    send_word(32'h0000_0002, 0, 1'b1, 1, 2);
    send_word(32'h0000_0003, 0, 1'b1, 2, 3);
    send_word(32'h0000_0004, 0, 1'b1, 3, 4);
    send_word(32'h5555_5555, 0, 1'b0, 0, 0);
    idle(2);
    check("ovf_done", done, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_count", word_count, 4);
    check("ovf_busy", busy, 0);

    // reset mid-load, with start in the same cycle
    pulse_start();
    check("restart_ovf_clr", overflow, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_count", word_count, 0);
    pulse_start();
    send_word(32'h1234_5678, 0, 1'b1, 0, 1);
    send_word(32'hFFFF_FFFF, 0, 1'b1, 1, 2);
    idle(2);
    check("midrst_final_count", word_count, 2);

`ifdef INSTR_LOADER_CHECKSUM_EN
    pulse_start();
    check("csum_cleared", checksum, 0);
    send_word(32'h0000_FFFF, 0, 1'b1, 0, 1);
    send_word(32'hFFFF_FFFF, 0, 1'b1, 1, 2);
    idle(2);
    check("csum_value", checksum, 32'hFFFF_0000);
`endif

    // final report
    idle(3);
    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
